// File: rtl/grf_wr_sched_pkg.sv
// Shared types and widths for the GRF write-port scheduler.
package grf_wr_sched_pkg;

  localparam int unsigned RegAddrW = 5;
  localparam int unsigned DataW    = 32;
  localparam int unsigned NumRegs  = 1 << RegAddrW;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StWait = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/grf_sb_hazard.sv
// Decode-stage hazard check against the long-latency scoreboard.
module grf_sb_hazard
  import grf_wr_sched_pkg::*;
(
  input  logic [NumRegs-1:0]  sb_i,
  input  logic                issue_valid_i,
  input  logic [RegAddrW-1:0] rs_i,
  input  logic [RegAddrW-1:0] rt_i,
  input  logic                use_rs_i,
  input  logic                use_rt_i,
  input  logic [RegAddrW-1:0] dst_i,
  input  logic                mdu_i,
  input  logic                mdu_busy_i,
  output logic                stall_o
);

  logic raw_rs;
  logic raw_rt;
  logic waw;
  logic mdu_conflict;

  always_comb begin
    raw_rs       = use_rs_i & sb_i[rs_i];
    raw_rt       = use_rt_i & sb_i[rt_i];
    waw          = (dst_i != '0) & sb_i[dst_i];
    // Only one MDU operation may be in flight.
    mdu_conflict = mdu_i & mdu_busy_i;
    stall_o      = issue_valid_i & (raw_rs | raw_rt | waw | mdu_conflict);
  end

endmodule

// File: rtl/grf_wr_sched.sv
// GRF write-port arbiter (W stage over MDU) with an MDU destination scoreboard
// and a BUSY-state timeout monitor.
module grf_wr_sched
  import grf_wr_sched_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 7
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Issue_Valid_In,
  input  logic [RegAddrW-1:0] Issue_Rs_In,
  input  logic [RegAddrW-1:0] Issue_Rt_In,
  input  logic                Issue_Use_Rs_In,
  input  logic                Issue_Use_Rt_In,
  input  logic [RegAddrW-1:0] Issue_Dst_In,
  input  logic                Issue_Mdu_In,
  output logic                Stall_Out,
  input  logic                Wb_Valid_In,
  input  logic [RegAddrW-1:0] Wb_A3_In,
  input  logic [DataW-1:0]    Wb_Wd_In,
  input  logic [DataW-1:0]    Wb_Pc_In,
  input  logic                Mdu_Valid_In,
  output logic                Mdu_Ready_Out,
  input  logic [RegAddrW-1:0] Mdu_A3_In,
  input  logic [DataW-1:0]    Mdu_Wd_In,
  input  logic [DataW-1:0]    Mdu_Pc_In,
  output logic                Grf_We_Out,
  output logic [RegAddrW-1:0] Grf_A3_Out,
  output logic [DataW-1:0]    Grf_Wd_Out,
  output logic [DataW-1:0]    Grf_Pc_Out,
  output logic                Mdu_Busy_Out,
  output logic                Mdu_Timeout_Out
);

  localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);

  mdu_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                timeout_q, timeout_d;
  logic [NumRegs-1:0]  sb_q, sb_d;
  logic                we_q, we_d;
  logic [RegAddrW-1:0] a3_q, a3_d;
  logic [DataW-1:0]    wd_q, wd_d;
  logic [DataW-1:0]    pc_q, pc_d;
  logic                src_mdu_q, src_mdu_d;

  logic mdu_busy;
  logic mdu_issue;
  logic mdu_accept;

  assign mdu_busy      = (state_q != StIdle);
  assign Mdu_Ready_Out = (state_q == StBusy) & ~Wb_Valid_In;
  assign mdu_issue     = Issue_Valid_In & ~Stall_Out & Issue_Mdu_In;
  assign mdu_accept    = Mdu_Valid_In & Mdu_Ready_Out;

  grf_sb_hazard u_hazard (
    .sb_i          (sb_q),
    .issue_valid_i (Issue_Valid_In),
    .rs_i          (Issue_Rs_In),
    .rt_i          (Issue_Rt_In),
    .use_rs_i      (Issue_Use_Rs_In),
    .use_rt_i      (Issue_Use_Rt_In),
    .dst_i         (Issue_Dst_In),
    .mdu_i         (Issue_Mdu_In),
    .mdu_busy_i    (mdu_busy),
    .stall_o       (Stall_Out)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    case (state_q)
      StIdle: begin
        if (mdu_issue) begin
          state_d = StBusy;
          cnt_d   = '0;
        end
      end
      StBusy: begin
        if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (cnt_d == TimeoutCnt) begin
          timeout_d = 1'b1;
        end
        if (mdu_accept) begin
          state_d = StWait;
        end
      end
      StWait:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // The clear lags the GRF write by one edge so a reader next cycle sees new data.
  always_comb begin
    sb_d = sb_q;
    if (we_q && src_mdu_q) begin
      sb_d[a3_q] = 1'b0;
    end
    if (mdu_issue && (Issue_Dst_In != '0)) begin
      sb_d[Issue_Dst_In] = 1'b1;
    end
    sb_d[0] = 1'b0;
  end

  always_comb begin
    we_d      = 1'b0;
    a3_d      = a3_q;
    wd_d      = wd_q;
    pc_d      = pc_q;
    src_mdu_d = 1'b0;
    if (Wb_Valid_In && (Wb_A3_In != '0)) begin
      we_d = 1'b1;
      a3_d = Wb_A3_In;
      wd_d = Wb_Wd_In;
      pc_d = Wb_Pc_In;
    end else if (mdu_accept && (Mdu_A3_In != '0)) begin
      we_d      = 1'b1;
      a3_d      = Mdu_A3_In;
      wd_d      = Mdu_Wd_In;
      pc_d      = Mdu_Pc_In;
      src_mdu_d = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      sb_q      <= '0;
      we_q      <= 1'b0;
      a3_q      <= '0;
      wd_q      <= '0;
      pc_q      <= '0;
      src_mdu_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      sb_q      <= sb_d;
      we_q      <= we_d;
      a3_q      <= a3_d;
      wd_q      <= wd_d;
      pc_q      <= pc_d;
      src_mdu_q <= src_mdu_d;
    end
  end

  assign Grf_We_Out      = we_q;
  assign Grf_A3_Out      = a3_q;
  assign Grf_Wd_Out      = wd_q;
  assign Grf_Pc_Out      = pc_q;
  assign Mdu_Busy_Out    = mdu_busy;
  assign Mdu_Timeout_Out = timeout_q;

endmodule

// File: tb/tb_grf_wr_sched.sv
// Self-checking bench for grf_wr_sched: directed scenarios then randomized traffic
// against a cycle-level reference model of the scoreboard, arbiter and MDU protocol.
module tb_grf_wr_sched;

  localparam int TO = 10;
  localparam int CW = 4;

  logic        Clk, Reset;
  logic        Issue_Valid_In, Issue_Use_Rs_In, Issue_Use_Rt_In, Issue_Mdu_In;
  logic [4:0]  Issue_Rs_In, Issue_Rt_In, Issue_Dst_In;
  logic        Stall_Out;
  logic        Wb_Valid_In;
  logic [4:0]  Wb_A3_In;
  logic [31:0] Wb_Wd_In, Wb_Pc_In;
  logic        Mdu_Valid_In, Mdu_Ready_Out;
  logic [4:0]  Mdu_A3_In;
  logic [31:0] Mdu_Wd_In, Mdu_Pc_In;
  logic        Grf_We_Out;
  logic [4:0]  Grf_A3_Out;
  logic [31:0] Grf_Wd_Out, Grf_Pc_Out;
  logic        Mdu_Busy_Out, Mdu_Timeout_Out;

  grf_wr_sched #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .Clk             (Clk),
    .Reset           (Reset),
    .Issue_Valid_In  (Issue_Valid_In),
    .Issue_Rs_In     (Issue_Rs_In),
    .Issue_Rt_In     (Issue_Rt_In),
    .Issue_Use_Rs_In (Issue_Use_Rs_In),
    .Issue_Use_Rt_In (Issue_Use_Rt_In),
    .Issue_Dst_In    (Issue_Dst_In),
    .Issue_Mdu_In    (Issue_Mdu_In),
    .Stall_Out       (Stall_Out),
    .Wb_Valid_In     (Wb_Valid_In),
    .Wb_A3_In        (Wb_A3_In),
    .Wb_Wd_In        (Wb_Wd_In),
    .Wb_Pc_In        (Wb_Pc_In),
    .Mdu_Valid_In    (Mdu_Valid_In),
    .Mdu_Ready_Out   (Mdu_Ready_Out),
    .Mdu_A3_In       (Mdu_A3_In),
    .Mdu_Wd_In       (Mdu_Wd_In),
    .Mdu_Pc_In       (Mdu_Pc_In),
    .Grf_We_Out      (Grf_We_Out),
    .Grf_A3_Out      (Grf_A3_Out),
    .Grf_Wd_Out      (Grf_Wd_Out),
    .Grf_Pc_Out      (Grf_Pc_Out),
    .Mdu_Busy_Out    (Mdu_Busy_Out),
    .Mdu_Timeout_Out (Mdu_Timeout_Out)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_tests = 0;
  int n_fail  = 0;
  int edge_cnt = 0;

  // Reference model: pending-register set, MDU operation phase, write-port image.
  bit        m_sb [32];
  int        m_phase;   // 0 none outstanding, 1 waiting for result, 2 result written
  int        m_cnt;
  bit        m_to;
  bit        m_we, m_src;
  bit [4:0]  m_a3;
  bit [31:0] m_wd, m_pc;

  // MDU agent
  bit        ag_pend, ag_shown;
  bit [4:0]  ag_dst;
  int        ag_delay;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    foreach (m_sb[i]) m_sb[i] = 1'b0;
    m_phase = 0; m_cnt = 0; m_to = 0;
    m_we = 0; m_src = 0; m_a3 = '0; m_wd = '0; m_pc = '0;
    ag_pend = 0; ag_shown = 0;
  endtask

  function automatic bit exp_stall();
    if (!Issue_Valid_In) return 1'b0;
    return (Issue_Use_Rs_In && m_sb[Issue_Rs_In]) || (Issue_Use_Rt_In && m_sb[Issue_Rt_In]) ||
           (Issue_Dst_In != 0 && m_sb[Issue_Dst_In]) || (Issue_Mdu_In && m_phase != 0);
  endfunction

  function automatic bit exp_ready();
    return (m_phase == 1) && !Wb_Valid_In;
  endfunction

  task automatic model_update(input bit st, input bit rd);
    bit iss_mdu, acc;
    if (!Reset) begin
      model_reset();
      return;
    end
    iss_mdu = Issue_Valid_In && !st && Issue_Mdu_In;
    acc     = Mdu_Valid_In && rd;
    if (m_we && m_src) m_sb[m_a3] = 1'b0;
    if (iss_mdu && Issue_Dst_In != 0) m_sb[Issue_Dst_In] = 1'b1;
    if (Wb_Valid_In && Wb_A3_In != 0) begin
      m_we = 1; m_src = 0; m_a3 = Wb_A3_In; m_wd = Wb_Wd_In; m_pc = Wb_Pc_In;
    end else if (acc && Mdu_A3_In != 0) begin
      m_we = 1; m_src = 1; m_a3 = Mdu_A3_In; m_wd = Mdu_Wd_In; m_pc = Mdu_Pc_In;
    end else begin
      m_we = 0; m_src = 0;
    end
    case (m_phase)
      0: if (iss_mdu) begin m_phase = 1; m_cnt = 0; end
      1: begin
        m_cnt++;
        if (m_cnt == TO) m_to = 1;
        if (acc) m_phase = 2;
      end
      default: m_phase = 0;
    endcase
    if (iss_mdu) begin
      ag_pend = 1; ag_shown = 0; ag_dst = Issue_Dst_In; ag_delay = $urandom_range(0, 14);
    end
    if (acc) ag_pend = 0;
  endtask

  // Inputs are stable when called (driven just after a posedge).
  task automatic step();
    bit st, rd;
    st = exp_stall();
    rd = exp_ready();
    @(negedge Clk);
    check("stall", Stall_Out, st);
    check("mdu_ready", Mdu_Ready_Out, rd);
    @(posedge Clk);
    model_update(st, rd);
    edge_cnt++;
    #1;
    check("grf_we", Grf_We_Out, m_we);
    check("grf_a3", Grf_A3_Out, m_a3);
    check("grf_wd", Grf_Wd_Out, m_wd);
    check("grf_pc", Grf_Pc_Out, m_pc);
    check("mdu_busy", Mdu_Busy_Out, m_phase != 0);
    check("mdu_timeout", Mdu_Timeout_Out, m_to);
  endtask

  task automatic idle_inputs();
    Issue_Valid_In = 0; Issue_Rs_In = 0; Issue_Rt_In = 0; Issue_Use_Rs_In = 0;
    Issue_Use_Rt_In = 0; Issue_Dst_In = 0; Issue_Mdu_In = 0;
    Wb_Valid_In = 0; Wb_A3_In = 0; Wb_Wd_In = 0; Wb_Pc_In = 0;
    Mdu_Valid_In = 0; Mdu_A3_In = 0; Mdu_Wd_In = 0; Mdu_Pc_In = 0;
  endtask

  task automatic issue(input bit mdu, input bit [4:0] dst, input bit urs, input bit [4:0] rs);
    Issue_Valid_In = 1; Issue_Mdu_In = mdu; Issue_Dst_In = dst;
    Issue_Use_Rs_In = urs; Issue_Rs_In = rs; Issue_Use_Rt_In = 0; Issue_Rt_In = 0;
  endtask

  task automatic random_inputs();
    Issue_Valid_In  = 1'($urandom);
    Issue_Rs_In     = 5'($urandom_range(0, 7));
    Issue_Rt_In     = 5'($urandom_range(0, 7));
    Issue_Use_Rs_In = 1'($urandom);
    Issue_Use_Rt_In = 1'($urandom);
    Issue_Dst_In    = 5'($urandom_range(0, 7));
    Issue_Mdu_In    = ($urandom_range(0, 3) == 0);
    Wb_Valid_In     = ($urandom_range(0, 2) == 0);
    Wb_A3_In        = 5'($urandom_range(0, 7));
    Wb_Wd_In        = $urandom;
    Wb_Pc_In        = $urandom;
  endtask

  task automatic mdu_agent();
    if (ag_pend && m_phase == 1) begin
      if (ag_delay > 0) begin
        ag_delay--;
        Mdu_Valid_In = 0;
      end else if (!ag_shown) begin
        ag_shown = 1;
        Mdu_Valid_In = 1; Mdu_A3_In = ag_dst; Mdu_Wd_In = $urandom; Mdu_Pc_In = $urandom;
      end
    end else begin
      // Spurious valid while idle must be ignored.
      Mdu_Valid_In = (m_phase == 0) && ($urandom_range(0, 9) == 0);
      Mdu_A3_In = 5'($urandom_range(0, 31)); Mdu_Wd_In = $urandom; Mdu_Pc_In = $urandom;
    end
  endtask

  initial begin
    int start, t;
    idle_inputs();
    Reset = 0;
    model_reset();

    // 1: reset with random inputs, then MDU issue to r8
    for (int i = 0; i < 3; i++) begin
      random_inputs();
      Mdu_Valid_In = 1'($urandom);
      step();
    end
    idle_inputs();
    Reset = 1;
    step();
    issue(1, 8, 0, 0);
    step();
    check("busy_after_issue", Mdu_Busy_Out, 1'b1);

    // 2: RAW stall on r8, MDU returns, stall drops a cycle after the write
    issue(0, 0, 1, 8);
    #1 check("raw_stall", Stall_Out, 1'b1);
    step();
    Mdu_Valid_In = 1; Mdu_A3_In = 8; Mdu_Wd_In = 32'h1234_5678; Mdu_Pc_In = 32'h3000;
    step();
    check("mdu_write_we", Grf_We_Out, 1'b1);
    check("mdu_write_a3", Grf_A3_Out, 5'd8);
    check("mdu_write_wd", Grf_Wd_Out, 32'h1234_5678);
    Mdu_Valid_In = 0;
    #1 check("raw_stall_write_cycle", Stall_Out, 1'b1);
    step();
    #1 check("raw_stall_released", Stall_Out, 1'b0);
    step();

    // 3: W stage wins the port, MDU follows next cycle
    idle_inputs();
    issue(1, 9, 0, 0);
    step();
    idle_inputs();
    Mdu_Valid_In = 1; Mdu_A3_In = 9; Mdu_Wd_In = 32'h55; Mdu_Pc_In = 32'h3004;
    Wb_Valid_In = 1; Wb_A3_In = 3; Wb_Wd_In = 32'hAA; Wb_Pc_In = 32'h3008;
    #1 check("wb_priority_ready", Mdu_Ready_Out, 1'b0);
    step();
    check("wb_first_a3", Grf_A3_Out, 5'd3);
    check("wb_first_wd", Grf_Wd_Out, 32'hAA);
    Wb_Valid_In = 0;
    step();
    check("mdu_second_we", Grf_We_Out, 1'b1);
    check("mdu_second_a3", Grf_A3_Out, 5'd9);
    Mdu_Valid_In = 0;
    step();
    step();

    // 4: structural and WAW stalls; 5: timeout then reset mid-BUSY
    issue(1, 8, 0, 0);
    step();
    start = edge_cnt;
    issue(1, 5, 0, 0);
    #1 check("second_mdu_stall", Stall_Out, 1'b1);
    step();
    issue(0, 8, 0, 0);
    #1 check("waw_stall", Stall_Out, 1'b1);
    step();
    idle_inputs();
    t = edge_cnt - start;
    while (!Mdu_Timeout_Out && t < 4 * TO) begin
      step();
      t = edge_cnt - start;
    end
    check("timeout_cycles", t, TO);
    step();
    check("timeout_sticky", Mdu_Timeout_Out, 1'b1);
    Reset = 0;
    model_reset();
    #1;
    check("reset_busy", Mdu_Busy_Out, 1'b0);
    check("reset_timeout", Mdu_Timeout_Out, 1'b0);
    step();
    Reset = 1;
    issue(0, 8, 1, 8);
    #1 check("reset_cleared_sb", Stall_Out, 1'b0);
    step();

    // 6: MDU result to r0 is discarded
    issue(1, 0, 0, 0);
    step();
    idle_inputs();
    Mdu_Valid_In = 1; Mdu_A3_In = 0; Mdu_Wd_In = 32'hDEAD_BEEF; Mdu_Pc_In = 32'h4000;
    step();
    check("a3_zero_no_we", Grf_We_Out, 1'b0);
    Mdu_Valid_In = 0;
    step();
    check("a3_zero_idle", Mdu_Busy_Out, 1'b0);
    issue(0, 8, 1, 8);
    #1 check("a3_zero_no_sb", Stall_Out, 1'b0);
    step();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        Reset = 0;
        model_reset();
      end else begin
        Reset = 1;
      end
      random_inputs();
      mdu_agent();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
